// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined ripple-chunk adder/subtractor with valid/ready handshake
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   in_a, in_b        operands (WIDTH bits)
//   in_cin            carry-in, ignored when in_sub=1
//   in_sub            0: A+B+cin, 1: A-B (A+~B+1)
//   in_valid/in_ready input handshake; in_ready is the global advance signal
//   out_sum           result modulo 2^WIDTH
//   out_cout          carry out of the MSB (subtract: 1 = no borrow)
//   out_ovf           signed two's-complement overflow
//   out_valid/out_ready output handshake
//
// Stage k adds chunk k-1 (C = WIDTH/STAGES bits) using the carry registered by
// the previous stage. Operands ride along the pipe so later stages see the
// bits they still have to add; finished sum chunks ride along as well.

module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int C = WIDTH / STAGES;

  logic              advance;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic              cy_q  [STAGES];
  logic              cy_d  [STAGES];

  // Carry into each stage's chunk: from the input for stage 1, else the
  // carry registered by the stage before it.
  logic              cy_in [STAGES];
  logic [WIDTH-1:0]  sum_in [STAGES];
  logic [C:0]        chunk [STAGES];

  // The whole pipe moves together; an empty output slot or an accepting
  // consumer lets every stage shift.
  assign advance  = !vld_q[STAGES-1] | out_ready;
  assign in_ready = advance;

  always_comb begin
    // Stage 1 sources come straight from the input port; B is inverted here
    // for subtraction so every later stage is a plain adder.
    vld_d[0]  = in_valid;
    a_d[0]    = in_a;
    b_d[0]    = in_sub ? ~in_b : in_b;
    cy_in[0]  = in_sub ? 1'b1 : in_cin;
    sum_in[0] = '0;
    for (int i = 1; i < STAGES; i++) begin
      vld_d[i]  = vld_q[i-1];
      a_d[i]    = a_q[i-1];
      b_d[i]    = b_q[i-1];
      cy_in[i]  = cy_q[i-1];
      sum_in[i] = sum_q[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      chunk[i] = {1'b0, a_d[i][i*C +: C]} + {1'b0, b_d[i][i*C +: C]} + {{C{1'b0}}, cy_in[i]};
      sum_d[i] = sum_in[i];
      sum_d[i][i*C +: C] = chunk[i][C-1:0];
      cy_d[i]  = chunk[i][C];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        sum_q[i] <= '0;
        cy_q[i]  <= 1'b0;
      end
    end else if (advance) begin
      vld_q <= vld_d;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i]   <= a_d[i];
        b_q[i]   <= b_d[i];
        sum_q[i] <= sum_d[i];
        cy_q[i]  <= cy_d[i];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_cout  = cy_q[STAGES-1];
  // Overflow: operands (after optional inversion) agree in sign but the
  // result does not. Cleared registers give 0 here after reset.
  assign out_ovf   = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &
                     (sum_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed and scoreboarded checks of pipelined_adder

module tb_pipelined_adder;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [15:0] in_a, in_b;
  logic        in_cin, in_sub;

  // dut0: WIDTH=8 STAGES=2, dut1: WIDTH=16 STAGES=4, dut2: WIDTH=8 STAGES=1
  logic        v0, r0, ov0, or0, c0, f0;
  logic [7:0]  s0;
  logic        v1, r1, ov1, or1, c1, f1;
  logic [15:0] s1;
  logic        v2, r2, ov2, or2, c2, f2;
  logic [7:0]  s2;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut0 (
    .clock(clock), .reset(reset), .in_a(in_a[7:0]), .in_b(in_b[7:0]),
    .in_cin(in_cin), .in_sub(in_sub), .in_valid(v0), .in_ready(r0),
    .out_sum(s0), .out_cout(c0), .out_ovf(f0), .out_valid(ov0), .out_ready(or0)
  );

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut1 (
    .clock(clock), .reset(reset), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .in_valid(v1), .in_ready(r1),
    .out_sum(s1), .out_cout(c1), .out_ovf(f1), .out_valid(ov1), .out_ready(or1)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut2 (
    .clock(clock), .reset(reset), .in_a(in_a[7:0]), .in_b(in_b[7:0]),
    .in_cin(in_cin), .in_sub(in_sub), .in_valid(v2), .in_ready(r2),
    .out_sum(s2), .out_cout(c2), .out_ovf(f2), .out_valid(ov2), .out_ready(or2)
  );

  int tests = 0;
  int fails = 0;

  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [17:0] q2[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    in_a   = a;
    in_b   = b;
    in_cin = cin;
    in_sub = sub;
  endtask

  // Reference result packed as {cout, ovf, sum[15:0]}.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [16:0] full;
    logic [15:0] aa, bb, sum;
    logic        carry, sa, sb, ss;
    if (w == 8) begin
      aa = {8'h00, a[7:0]};
      bb = sub ? {8'h00, ~b[7:0]} : {8'h00, b[7:0]};
    end else begin
      aa = a;
      bb = sub ? ~b : b;
    end
    full = {1'b0, aa} + {1'b0, bb} + {16'h0000, (sub ? 1'b1 : cin)};
    if (w == 8) begin
      carry = full[8];
      sum   = {8'h00, full[7:0]};
      sa = aa[7]; sb = bb[7]; ss = full[7];
    end else begin
      carry = full[16];
      sum   = full[15:0];
      sa = aa[15]; sb = bb[15]; ss = full[15];
    end
    return {carry, (sa == sb) && (ss != sa), sum};
  endfunction

  // One scoreboard cycle: inputs are already set; look at what transfers on
  // the coming edge, then take the edge.
  task automatic sb_step();
    #1;
    if (ov0 && or0) begin
      chk("sb0_nonempty", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) chk("sb0_result", {c0, f0, 8'h00, s0}, q0.pop_front());
    end
    if (ov1 && or1) begin
      chk("sb1_nonempty", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) chk("sb1_result", {c1, f1, s1}, q1.pop_front());
    end
    if (ov2 && or2) begin
      chk("sb2_nonempty", 32'(q2.size() != 0), 1);
      if (q2.size() != 0) chk("sb2_result", {c2, f2, 8'h00, s2}, q2.pop_front());
    end
    if (v0 && r0) q0.push_back(model(8, in_a, in_b, in_cin, in_sub));
    if (v1 && r1) q1.push_back(model(16, in_a, in_b, in_cin, in_sub));
    if (v2 && r2) q2.push_back(model(8, in_a, in_b, in_cin, in_sub));
    tick();
  endtask

  initial begin
    reset = 1'b1;
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    or0 = 1'b1; or1 = 1'b1; or2 = 1'b1;

    // Reset: two cycles, in_ready high throughout
    tick();
    chk("ready_during_reset", r0, 1);
    tick();
    reset = 1'b0;
    chk("reset_outputs", {ov0, c0, f0, s0}, 0);
    chk("reset_in_ready", r0, 1);

    // 0+0: two-cycle latency, single valid cycle
    drive(16'h00, 16'h00, 1'b0, 1'b0);
    v0 = 1'b1;
    tick();
    v0 = 1'b0;
    chk("zero_not_yet", ov0, 0);
    tick();
    chk("zero_result", {ov0, c0, f0, s0}, {1'b1, 1'b0, 1'b0, 8'h00});
    tick();
    chk("zero_one_cycle", ov0, 0);

    // 0xFF+0x01: carry crosses the chunk boundary; STAGES=1 instance has latency 1
    drive(16'hFF, 16'h01, 1'b0, 1'b0);
    v0 = 1'b1; v2 = 1'b1;
    tick();
    v0 = 1'b0; v2 = 1'b0;
    chk("s1_latency1", {ov2, c2, f2, s2}, {1'b1, 1'b1, 1'b0, 8'h00});
    tick();
    chk("carry_chain", {ov0, c0, f0, s0}, {1'b1, 1'b1, 1'b0, 8'h00});
    tick();

    // Back-to-back, one per cycle
    drive(16'h05, 16'h07, 1'b0, 1'b1);
    v0 = 1'b1;
    chk("b2b_ready0", r0, 1);
    tick();
    drive(16'h7F, 16'h01, 1'b0, 1'b0);
    chk("b2b_ready1", r0, 1);
    tick();
    chk("b2b_sub_neg", {ov0, c0, f0, s0}, {1'b1, 1'b0, 1'b0, 8'hFE});
    drive(16'h80, 16'h01, 1'b0, 1'b1);
    chk("b2b_ready2", r0, 1);
    tick();
    chk("b2b_pos_ovf", {ov0, c0, f0, s0}, {1'b1, 1'b0, 1'b1, 8'h80});
    v0 = 1'b0;
    tick();
    chk("b2b_sub_ovf", {ov0, c0, f0, s0}, {1'b1, 1'b1, 1'b1, 8'h7F});
    tick();
    chk("b2b_drained", ov0, 0);

    // Backpressure: out_ready low while four inputs are offered
    or0 = 1'b0;
    drive(16'h10, 16'h20, 1'b1, 1'b0);
    v0 = 1'b1;
    chk("bp_ready_x0", r0, 1);
    tick();
    chk("bp_not_full", ov0, 0);
    drive(16'hC0, 16'h50, 1'b0, 1'b0);
    chk("bp_ready_x1", r0, 1);
    tick();
    drive(16'h30, 16'h30, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_head_stable", {ov0, c0, f0, s0}, {1'b1, 1'b0, 1'b0, 8'h31});
      chk("bp_in_ready_low", r0, 0);
      tick();
    end
    chk("bp_head_final", {ov0, c0, f0, s0}, {1'b1, 1'b0, 1'b0, 8'h31});
    or0 = 1'b1;
    #1;
    chk("bp_release_ready", r0, 1);
    tick();
    chk("bp_x1", {ov0, c0, f0, s0}, {1'b1, 1'b1, 1'b0, 8'h10});
    drive(16'h40, 16'h40, 1'b1, 1'b0);
    tick();
    chk("bp_x2", {ov0, c0, f0, s0}, {1'b1, 1'b1, 1'b0, 8'h00});
    v0 = 1'b0;
    tick();
    chk("bp_x3", {ov0, c0, f0, s0}, {1'b1, 1'b0, 1'b1, 8'h81});
    tick();
    chk("bp_drained", ov0, 0);

    // Reset with two operations in flight
    or0 = 1'b0;
    drive(16'h01, 16'h02, 1'b0, 1'b0);
    v0 = 1'b1;
    tick();
    drive(16'h03, 16'h04, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    v0 = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_flush", {ov0, c0, f0, s0}, 0);
    or0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_stale", ov0, 0);
    end

    // Random sweep over three geometries with random valid/ready
    for (int n = 0; n < 2500; n++) begin
      in_a   = 16'($urandom);
      in_b   = 16'($urandom);
      in_cin = 1'($urandom);
      in_sub = 1'($urandom);
      v0  = ($urandom_range(0, 9) < 7);
      v1  = ($urandom_range(0, 9) < 7);
      v2  = ($urandom_range(0, 9) < 7);
      or0 = ($urandom_range(0, 9) < 7);
      or1 = ($urandom_range(0, 9) < 7);
      or2 = ($urandom_range(0, 9) < 7);
      sb_step();
    end
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    or0 = 1'b1; or1 = 1'b1; or2 = 1'b1;
    for (int n = 0; n < 20; n++) sb_step();
    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    chk("sb2_drained", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
